// File: rtl/sram_spi_master.sv
// SPI mode-0 initiator for a 23LC1024-class serial SRAM: single-byte READ (0x03) / WRITE (0x02).
// Define SRAM_RSTIO_EN to issue one autonomous RSTIO (0xFF) frame after every reset release.
module sram_spi_master #(
  parameter int CLK_DIV   = 4,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 rd_wr,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wr_data,
  output logic [7:0]           rd_data,
  output logic                 done,
  output logic                 busy,
  output logic                 sram_spi_cs,
  output logic                 sram_spi_clk,
  output logic                 sram_spi_mosi,
  input  logic                 sram_spi_miso
);

  localparam int FRAME_BITS = 16 + ADDR_BITS;
  localparam int HC_W = $clog2(CLK_DIV + 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t                  state_q, state_d;
  logic [HC_W-1:0]         hc_q, hc_d;
  logic [5:0]              bc_q, bc_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic                    done_q, done_d;
  logic                    rd_q, rd_d;
  logic [7:0]              rd_data_q, rd_data_d;
  logic [7:0]              rx_q, rx_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   frame;
  logic                    hc_last, bit_last, launch_user, launch_rstio;

`ifdef SRAM_RSTIO_EN
  logic rstio_q, rstio_d, rstio_pend_q, rstio_pend_d;
`else
  logic rstio_q, rstio_pend_q;
  assign rstio_q      = 1'b0;
  assign rstio_pend_q = 1'b0;
`endif

  assign hc_last      = (hc_q == HC_LAST);
  assign bit_last     = rstio_q ? (bc_q == 6'd7) : (bc_q == BIT_LAST);
  assign launch_rstio = (state_q == S_IDLE) && rstio_pend_q;
  assign launch_user  = (state_q == S_IDLE) && start && !rstio_pend_q;

  // State and control registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      hc_q      <= '0;
      bc_q      <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      rd_data_q <= 8'h00;
`ifdef SRAM_RSTIO_EN
      rstio_q      <= 1'b0;
      rstio_pend_q <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      bc_q      <= bc_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
`ifdef SRAM_RSTIO_EN
      rstio_q      <= rstio_d;
      rstio_pend_q <= rstio_pend_d;
`endif
    end
  end

  // Shift registers carry pure data and need no reset.
  always_ff @(posedge clk) begin
    tx_q <= tx_d;
    rx_q <= rx_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (launch_user || launch_rstio) state_d = S_CS_SETUP;
      S_CS_SETUP: if (hc_last) state_d = S_SHIFT;
      S_SHIFT:    if (hc_last && sclk_q && bit_last) state_d = S_CS_HOLD;
      S_CS_HOLD:  if (hc_last) state_d = S_CS_GAP;
      S_CS_GAP:   if (hc_last) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hc_d      = '0;
    bc_d      = bc_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    frame     = {rd_wr ? 8'h03 : 8'h02, addr, rd_wr ? 8'h00 : wr_data};
`ifdef SRAM_RSTIO_EN
    rstio_d      = rstio_q;
    rstio_pend_d = rstio_pend_q;
    if (launch_rstio) frame = {8'hFF, {(FRAME_BITS - 8){1'b0}}};
`endif
    if (state_q != S_IDLE) hc_d = hc_last ? '0 : hc_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (launch_user || launch_rstio) begin
          // First bit is presented together with CS assertion.
          cs_d   = 1'b0;
          mosi_d = frame[FRAME_BITS-1];
          tx_d   = frame << 1;
          bc_d   = '0;
          rd_d   = launch_user && rd_wr;
`ifdef SRAM_RSTIO_EN
          rstio_d      = launch_rstio;
          rstio_pend_d = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (hc_last) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[6:0], sram_spi_miso};
          end else begin
            sclk_d = 1'b0;
            if (bit_last) begin
              mosi_d = 1'b0;
            end else begin
              bc_d   = bc_q + 6'd1;
              mosi_d = tx_q[FRAME_BITS-1];
              tx_d   = tx_q << 1;
            end
          end
        end
      end
      S_CS_HOLD: if (hc_last) cs_d = 1'b1;
      S_CS_GAP: begin
        if (hc_last) begin
          done_d = !rstio_q;
          if (rd_q && !rstio_q) rd_data_d = rx_q;
`ifdef SRAM_RSTIO_EN
          rstio_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign rd_data       = rd_data_q;
  assign sram_spi_cs   = cs_q;
  assign sram_spi_clk  = sclk_q;
  assign sram_spi_mosi = mosi_q;

endmodule

// File: tb/tb_sram_spi_master.sv
// Directed bench for sram_spi_master: CLK_DIV=4 and CLK_DIV=1 instances share one serial SRAM model.
module tb_sram_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start, rd_wr, sel1;
  logic [23:0] addr;
  logic [7:0]  wr_data, ret_byte;
  logic        miso = 1'b0;
  logic        start4, start1;
  logic [7:0]  rd_data4, rd_data1;
  logic        done4, busy4, cs4, sclk4, mosi4;
  logic        done1, busy1, cs1, sclk1, mosi1;
  logic [7:0]  v_rd_data;
  logic        v_done, v_busy, v_cs, v_sclk, v_mosi;

  int n_checks = 0;
  int n_fail   = 0;

  assign start4    = start & ~sel1;
  assign start1    = start & sel1;
  assign v_rd_data = sel1 ? rd_data1 : rd_data4;
  assign v_done    = sel1 ? done1 : done4;
  assign v_busy    = sel1 ? busy1 : busy4;
  assign v_cs      = sel1 ? cs1 : cs4;
  assign v_sclk    = sel1 ? sclk1 : sclk4;
  assign v_mosi    = sel1 ? mosi1 : mosi4;

  sram_spi_master #(.CLK_DIV(4), .ADDR_BITS(24)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .rd_wr(rd_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data4), .done(done4), .busy(busy4),
    .sram_spi_cs(cs4), .sram_spi_clk(sclk4), .sram_spi_mosi(mosi4), .sram_spi_miso(miso));

  sram_spi_master #(.CLK_DIV(1), .ADDR_BITS(24)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .rd_wr(rd_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data1), .done(done1), .busy(busy1),
    .sram_spi_cs(cs1), .sram_spi_clk(sclk1), .sram_spi_mosi(mosi1), .sram_spi_miso(miso));

  // SRAM model: capture MOSI on SCLK rise, drive the read byte for bits 33..40.
  int          bit_cnt = 0;
  logic [39:0] mosi_cap = '0;
  always @(posedge v_sclk or negedge v_cs) begin
    if (!v_sclk) begin
      bit_cnt  = 0;
      mosi_cap = '0;
      miso     = 1'b0;
    end else if (!v_cs) begin
      mosi_cap = {mosi_cap[38:0], v_mosi};
      bit_cnt++;
      if (bit_cnt >= 32 && bit_cnt < 40) miso = ret_byte[39-bit_cnt];
      else miso = 1'b0;
    end
  end

  task automatic do_frame(input logic rd, input logic [23:0] a, input logic [7:0] d,
                          output int lat, output int cs_low, output logic b1, output logic c1);
    rd_wr = rd; addr = a; wr_data = d; start = 1'b1;
    lat = -1; cs_low = 0; b1 = 1'b0; c1 = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin b1 = v_busy; c1 = v_cs; end
      if (!v_cs) cs_low++;
      if (v_done) begin lat = cyc - 1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; rd_wr = 1'b0; addr = '0; wr_data = '0;
    sel1 = 1'b0; ret_byte = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (v_cs !== 1'b1)   begin n_fail++; $display("FAIL reset_cs: got %b want 1", v_cs); end
    n_checks++; if (v_sclk !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", v_sclk); end
    n_checks++; if (v_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", v_mosi); end
    n_checks++; if (v_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", v_busy); end
    n_checks++; if (v_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", v_done); end
    n_checks++; if (v_rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", v_rd_data); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int lat, csl; logic b1, c1;
    do_frame(1'b0, 24'h012345, 8'h5A, lat, csl, b1, c1);
    n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL wr_busy_rise: got %b want 1", b1); end
    n_checks++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL wr_cs_assert: got %b want 0", c1); end
    n_checks++; if (mosi_cap !== 40'h02_012345_5A) begin n_fail++; $display("FAIL wr_mosi: got %h want 02012345 5a", mosi_cap); end
    n_checks++; if (bit_cnt !== 40) begin n_fail++; $display("FAIL wr_sclk_pulses: got %0d want 40", bit_cnt); end
    n_checks++; if (lat !== 332) begin n_fail++; $display("FAIL wr_latency: got %0d want 332", lat); end
    n_checks++; if (csl !== 328) begin n_fail++; $display("FAIL wr_cs_low: got %0d want 328", csl); end
    n_checks++; if (v_busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_fall: got %b want 0", v_busy); end
    n_checks++; if (v_rd_data !== 8'h00) begin n_fail++; $display("FAIL wr_rd_data: got %h want 00", v_rd_data); end
    @(negedge clk);
    n_checks++; if (v_done !== 1'b0) begin n_fail++; $display("FAIL wr_done_pulse: got %b want 0", v_done); end
  endtask

  task automatic test_read;
    int lat, csl; logic b1, c1;
    ret_byte = 8'hA5;
    do_frame(1'b1, 24'h00FFFF, 8'h33, lat, csl, b1, c1);
    n_checks++; if (mosi_cap !== 40'h03_00FFFF_00) begin n_fail++; $display("FAIL rd_mosi: got %h want 0300ffff00", mosi_cap); end
    n_checks++; if (lat !== 332) begin n_fail++; $display("FAIL rd_latency: got %0d want 332", lat); end
    n_checks++; if (v_rd_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", v_rd_data); end
    ret_byte = 8'h00;
    @(negedge clk);
    do_frame(1'b0, 24'h000100, 8'hC7, lat, csl, b1, c1);
    n_checks++; if (mosi_cap !== 40'h02_000100_C7) begin n_fail++; $display("FAIL rd_follow_wr_mosi: got %h want 02000100c7", mosi_cap); end
    n_checks++; if (v_rd_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data_held: got %h want a5", v_rd_data); end
  endtask

  task automatic test_start_while_busy;
    int dones = 0, lat = -1, busy_after = 0;
    rd_wr = 1'b0; addr = 24'h111111; wr_data = 8'h22; start = 1'b1;
    for (int cyc = 1; cyc <= 800; cyc++) begin
      @(negedge clk);
      start = (cyc == 10 || cyc == 100);
      if (v_done) begin dones++; if (lat < 0) lat = cyc - 1; end
      if (lat >= 0 && !v_done && v_busy) busy_after++;
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL busy_ignore_dones: got %0d want 1", dones); end
    n_checks++; if (lat !== 332) begin n_fail++; $display("FAIL busy_ignore_latency: got %0d want 332", lat); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL busy_ignore_queued: got %0d busy cycles want 0", busy_after); end
  endtask

  task automatic test_start_at_busy_fall;
    int lat = -1, busy_after = 0;
    rd_wr = 1'b0; addr = 24'h222222; wr_data = 8'h44; start = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      start = (cyc == 332);
      if (v_done) begin lat = cyc - 1; break; end
    end
    start = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (v_busy) busy_after++;
    end
    n_checks++; if (lat !== 332) begin n_fail++; $display("FAIL fall_start_latency: got %0d want 332", lat); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL fall_start_accepted: got %0d busy cycles want 0", busy_after); end
  endtask

  task automatic test_reset_mid_frame;
    int dones = 0, lat, csl; logic b1, c1; logic reached = 1'b0;
    ret_byte = 8'h5C;
    do_frame(1'b1, 24'h0000AA, 8'h00, lat, csl, b1, c1);
    n_checks++; if (v_rd_data !== 8'h5C) begin n_fail++; $display("FAIL mid_pre_rd_data: got %h want 5c", v_rd_data); end
    @(negedge clk);
    rd_wr = 1'b1; addr = 24'h0000BB; start = 1'b1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v_done) dones++;
      if (bit_cnt >= 20) begin reached = 1'b1; break; end
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL mid_reach_bit20: got %b want 1", reached); end
    reset_n = 1'b0;
    @(negedge clk);
    if (v_done) dones++;
    n_checks++; if (v_cs !== 1'b1)   begin n_fail++; $display("FAIL mid_cs: got %b want 1", v_cs); end
    n_checks++; if (v_sclk !== 1'b0) begin n_fail++; $display("FAIL mid_sclk: got %b want 0", v_sclk); end
    n_checks++; if (v_mosi !== 1'b0) begin n_fail++; $display("FAIL mid_mosi: got %b want 0", v_mosi); end
    n_checks++; if (v_busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", v_busy); end
    n_checks++; if (v_rd_data !== 8'h00) begin n_fail++; $display("FAIL mid_rd_data: got %h want 00", v_rd_data); end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", dones); end
    reset_n = 1'b1;
    ret_byte = 8'h00;
    repeat (2) @(negedge clk);
    do_frame(1'b0, 24'h0ABCDE, 8'h77, lat, csl, b1, c1);
    n_checks++; if (mosi_cap !== 40'h02_0ABCDE_77) begin n_fail++; $display("FAIL mid_clean_mosi: got %h want 020abcde77", mosi_cap); end
    n_checks++; if (bit_cnt !== 40) begin n_fail++; $display("FAIL mid_clean_pulses: got %0d want 40", bit_cnt); end
    n_checks++; if (lat !== 332) begin n_fail++; $display("FAIL mid_clean_latency: got %0d want 332", lat); end
  endtask

  task automatic test_back_to_back;
    int lat, csl; logic b1, c1;
    sel1 = 1'b1;
    @(negedge clk);
    ret_byte = 8'h3C;
    do_frame(1'b1, 24'h000010, 8'h00, lat, csl, b1, c1);
    n_checks++; if (mosi_cap !== 40'h03_000010_00) begin n_fail++; $display("FAIL b2b_rd1_mosi: got %h want 0300001000", mosi_cap); end
    n_checks++; if (lat !== 83) begin n_fail++; $display("FAIL b2b_rd1_latency: got %0d want 83", lat); end
    n_checks++; if (csl !== 82) begin n_fail++; $display("FAIL b2b_rd1_cs_low: got %0d want 82", csl); end
    n_checks++; if (v_rd_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_rd1_data: got %h want 3c", v_rd_data); end
    ret_byte = 8'h00;
    do_frame(1'b0, 24'h000011, 8'hC3, lat, csl, b1, c1);
    n_checks++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_wr_accept: got cs %b want 0", c1); end
    n_checks++; if (mosi_cap !== 40'h02_000011_C3) begin n_fail++; $display("FAIL b2b_wr_mosi: got %h want 02000011c3", mosi_cap); end
    n_checks++; if (lat !== 83) begin n_fail++; $display("FAIL b2b_wr_latency: got %0d want 83", lat); end
    n_checks++; if (csl !== 82) begin n_fail++; $display("FAIL b2b_wr_cs_low: got %0d want 82", csl); end
    n_checks++; if (v_rd_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_wr_rd_held: got %h want 3c", v_rd_data); end
    ret_byte = 8'h96;
    do_frame(1'b1, 24'h000012, 8'h00, lat, csl, b1, c1);
    n_checks++; if (c1 !== 1'b0) begin n_fail++; $display("FAIL b2b_rd2_accept: got cs %b want 0", c1); end
    n_checks++; if (mosi_cap !== 40'h03_000012_00) begin n_fail++; $display("FAIL b2b_rd2_mosi: got %h want 0300001200", mosi_cap); end
    n_checks++; if (lat !== 83) begin n_fail++; $display("FAIL b2b_rd2_latency: got %0d want 83", lat); end
    n_checks++; if (v_rd_data !== 8'h96) begin n_fail++; $display("FAIL b2b_rd2_data: got %h want 96", v_rd_data); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_start_while_busy();
    test_start_at_busy_fall();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_spi_master.md
Name: sram_spi_master

Overview:
- SPI initiator (master) that drives the external serial SRAM (23LC1024-class) in single-bit SPI mode 0.
- It is the counterpart of the FPGA's SPI slave register interface: the FPGA originates the frames here rather than responding to them.
- Performs single-byte READ (0x03) and WRITE (0x02) transactions with 24-bit addresses, requested by the system register/audio logic.
- Sits between the register-side request signals and the top-level sram_spi_* pins; sio[0] carries SI and sio[1] carries SO, mapped at top level.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- ADDR_BITS, 24: address field width sent on the wire.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle transaction request; accepted only when busy=0.
- rd_wr  in  1  1=read, 0=write; sampled with start.
- addr  in  ADDR_BITS  byte address; sampled with start.
- wr_data  in  8  write byte; sampled with start.
- rd_data  out  8  last byte read.
- done  out  1  one-cycle pulse at end of frame.
- busy  out  1  high while a frame is in progress.
- sram_spi_cs  out  1  chip select, active-low.
- sram_spi_clk  out  1  SCLK, idles low.
- sram_spi_mosi  out  1  serial data to the SRAM.
- sram_spi_miso  in  1  serial data from the SRAM.

Behaviour:
- Reset values: sram_spi_cs=1, sram_spi_clk=0, sram_spi_mosi=0, busy=0, done=0, rd_data=8'h00.
- States:
  - IDLE
  - CS_SETUP: CLK_DIV cycles.
  - SHIFT: 40 bits = 8 command + 24 address + 8 data.
  - CS_HOLD: CLK_DIV cycles.
  - CS_GAP: CLK_DIV cycles.
- Transitions: IDLE→CS_SETUP on start; CS_SETUP→SHIFT; SHIFT→CS_HOLD after bit 40 completes; CS_HOLD→CS_GAP; CS_GAP→IDLE.
- Start acceptance: start sampled in IDLE at edge N. busy=1 and sram_spi_cs=0 from edge N+1. rd_wr, addr and wr_data are captured into internal registers at edge N.
- Bit timing: each bit lasts 2*CLK_DIV clocks; SCLK is low for the first half and high for the second.
  - MOSI is updated at the start of the low half; bit 0 is presented at CS assertion.
  - MISO is sampled on the clk edge where SCLK rises.
  - All fields are sent MSB first.
- Write frame: MOSI carries 0x02, addr, wr_data.
- Read frame: MOSI carries 0x03, addr, then 0 during the data phase. The 8 MISO samples of the data phase are shifted into a register that is copied to rd_data at frame end.
- Frame length: 2*CLK_DIV*40 + 3*CLK_DIV clocks from the start edge to busy falling. For CLK_DIV=4 this is 332.
- done: pulses 1 cycle on the edge busy falls.
  - Reads: rd_data is updated on that same edge and held until the next read's done.
  - Writes: rd_data is unchanged.
- start while busy: ignored, not queued.
- start on the cycle busy falls: ignored. The earliest accepted start is the cycle after done.
- Reset mid-frame, at the first reset edge:
  - sram_spi_cs=1, sram_spi_clk=0, mosi=0.
  - The FSM returns to IDLE and the frame is abandoned.
  - done is not pulsed and rd_data is cleared.
- Counter widths:
  - Half-period counter: ceil(log2(CLK_DIV+1)) bits, wraps at CLK_DIV-1.
  - Bit counter: 6 bits, terminal count 39.
- Don't-care field: address bits above the part's used width are transmitted as given.

Optional Feature:
- SRAM_RSTIO_EN defined:
  - After reset deassertion the block autonomously issues one 8-bit RSTIO frame (command 0xFF, no address or data), forcing the part out of SDI/SQI into SPI mode.
  - Timing: CS_SETUP + 8 bits + CS_HOLD + CS_GAP.
  - busy=1 throughout this frame; done is not pulsed and start is ignored.
  - Reset during the RSTIO frame restarts it.
- Undefined: the block is idle in IDLE immediately after reset with no autonomous frame; SPI mode is assumed from power-up.

Test Plan:
- Write, CLK_DIV=4: start with rd_wr=0, addr=0x012345, wr_data=0x5A → MOSI sampled on SCLK rises = 0x02,0x01,0x23,0x45,0x5A; CS low for the whole frame; 40 SCLK pulses; done at +332 cycles; rd_data unchanged.
- Read, SRAM model returns 0xA5: start with rd_wr=1, addr=0x00FFFF → MOSI = 0x03,0x00,0xFF,0xFF,0x00; rd_data=0xA5 on the done cycle and held through a subsequent write.
- start pulsed at cycles 10 and 100 after an accepted start → exactly one frame; done pulses once; the second start is not queued.
- reset_n low at bit 20 → next edge CS=1, SCLK=0, busy=0, rd_data=0x00; no done; a new start after release runs a clean 40-bit frame.
- CLK_DIV=1, back-to-back read, write, read, each started the cycle after done → each frame is 83 cycles; CS high for ≥1 cycle between frames; correct data each time.
- With SRAM_RSTIO_EN: release reset → busy=1, 8 SCLK pulses with MOSI=1, CS high afterward, no done; start during this frame is ignored.
